// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
package seg_scan_pkg;

   // Per-slot phase: blank for anti-ghosting, then show the digit.
   typedef enum logic {
      StBlank = 1'b0,
      StShow  = 1'b1
   } scan_state_e;

   // Digit code that must light nothing, regardless of the decoder table.
   localparam logic [4:0] BLANK_CODE = 5'h1F;

   // Segment pattern with every segment dark.
   localparam logic [7:0] SEG_OFF = 8'h00;

endpackage

// File: rtl/seg_scan_bin2sevenSeg.sv
// Shared 5-bit to seven-segment decoder. Codes 0..9 give the digit shapes,
// every other code lights all segments (lamp test).
// Bit map: 7=a 6=f 5=b 4=g 3=c 2=dp 1=d 0=e, active-high.
module bin2sevenSeg (
   input  logic [4:0] code,
   output logic [7:0] seg
);

   // Combinational lookup of the segment pattern for one code.
   always_comb begin
      seg = 8'hFF;
      unique case (code)
         5'd0:    seg = 8'hEB;
         5'd1:    seg = 8'h28;
         5'd2:    seg = 8'hB3;
         5'd3:    seg = 8'hBA;
         5'd4:    seg = 8'h78;
         5'd5:    seg = 8'hDA;
         5'd6:    seg = 8'hDB;
         5'd7:    seg = 8'hA8;
         5'd8:    seg = 8'hFB;
         5'd9:    seg = 8'hFA;
         default: seg = 8'hFF;
      endcase
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment display scanner with a blank/show slot FSM,
// a double-buffered frame of digit codes and a frame-start pulse.
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int unsigned N_DIGITS  = 4,
   parameter int unsigned SCAN_DIV  = 50000,
   parameter int unsigned BLANK_CYC = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [5*N_DIGITS-1:0] wr_data,
   input  logic [N_DIGITS-1:0]   digit_en,
   output logic [7:0]            display,
   output logic [N_DIGITS-1:0]   digit_sel,
   output logic                  frame_start
);

   localparam int unsigned CNT_W = $clog2(SCAN_DIV);
   localparam int unsigned IDX_W = $clog2(N_DIGITS);

   localparam logic [CNT_W-1:0] CNT_BLANK_END = CNT_W'(BLANK_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(N_DIGITS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE       = IDX_W'(1);

   scan_state_e           state;
   logic [CNT_W-1:0]      cnt;
   logic [IDX_W-1:0]      idx;

   // shadow is what is being displayed, pending is the next frame waiting for a wrap.
   logic [5*N_DIGITS-1:0] shadow;
   logic [5*N_DIGITS-1:0] pending;
   logic                  pending_full;

   logic [4:0]            code_sel;
   logic [7:0]            dec_seg;
   logic [7:0]            seg_val;
   logic                  lit;
   logic                  slot_end;
   logic                  frame_wrap;
   logic                  frame_head;
   logic [N_DIGITS-1:0]   sel_next;

   assign code_sel   = shadow[5*int'(idx) +: 5];
   assign slot_end   = (state == StShow) && (cnt == CNT_LAST);
   assign frame_wrap = slot_end && (idx == IDX_LAST);
   assign frame_head = (state == StBlank) && (cnt == '0) && (idx == '0);
   assign lit        = (state == StShow) && digit_en[idx];
   assign wr_ready   = !pending_full;

   bin2sevenSeg u_dec (
      .code (code_sel),
      .seg  (dec_seg)
   );

   // The blank code is forced dark here so the shared decoder stays untouched.
   assign seg_val = (code_sel == BLANK_CODE) ? SEG_OFF : dec_seg;

   // Active-low select for the current digit, all high when nothing is lit.
   always_comb begin
      sel_next = '1;
      if (lit) begin
         sel_next[idx] = 1'b0;
      end
   end

   // Slot FSM with the registered display, select and frame-start outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= StBlank;
         cnt         <= '0;
         idx         <= '0;
         display     <= SEG_OFF;
         digit_sel   <= '1;
         frame_start <= 1'b0;
      end else begin
         display     <= lit ? seg_val : SEG_OFF;
         digit_sel   <= sel_next;
         frame_start <= frame_head;
         unique case (state)
            StBlank: begin
               cnt <= cnt + CNT_ONE;
               if (cnt == CNT_BLANK_END) begin
                  state <= StShow;
               end
            end
            StShow: begin
               if (cnt == CNT_LAST) begin
                  cnt   <= '0;
                  state <= StBlank;
                  idx   <= (idx == IDX_LAST) ? '0 : idx + IDX_ONE;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
         endcase
      end
   end

   // Frame buffer: a pending frame is only promoted at a frame wrap so a
   // displayed frame never mixes old and new codes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow       <= {N_DIGITS{BLANK_CODE}};
         pending      <= {N_DIGITS{BLANK_CODE}};
         pending_full <= 1'b0;
      end else if (frame_wrap && pending_full) begin
         shadow       <= pending;
         pending_full <= 1'b0;
      end else if (wr_valid && wr_ready) begin
         pending      <= wr_data;
         pending_full <= 1'b1;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: frame-position model plus directed literal pins.
module tb_seg_scan_ctrl;

   localparam int N     = 4;
   localparam int DIV   = 8;
   localparam int BLK   = 2;
   localparam int FRAME = N * DIV;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [5*N-1:0] wr_data = '0;
   logic [N-1:0]  digit_en = '1;
   logic [7:0]    display;
   logic [N-1:0]  digit_sel;
   logic          frame_start;

   always #5 clk = ~clk;

   seg_scan_ctrl #(
      .N_DIGITS  (N),
      .SCAN_DIV  (DIV),
      .BLANK_CYC (BLK)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_data     (wr_data),
      .digit_en    (digit_en),
      .display     (display),
      .digit_sel   (digit_sel),
      .frame_start (frame_start)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Model: pos counts cycles since reset release; the frame is a plain array.
   int         pos;
   logic [4:0] sh [N];
   logic [4:0] pd [N];
   bit         pd_full;
   logic [7:0] e_disp;
   logic [N-1:0] e_sel;
   logic       e_fs;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at t=%0t pos=%0d", name, act, exp, $time, pos);
      end
   endtask

   function automatic logic [7:0] seg_of(input logic [4:0] c);
      logic [7:0] tbl [10] = '{8'hEB, 8'h28, 8'hB3, 8'hBA, 8'h78,
                               8'hDA, 8'hDB, 8'hA8, 8'hFB, 8'hFA};
      if (c == 5'h1F) return 8'h00;
      if (c > 5'd9) return 8'hFF;
      return tbl[c];
   endfunction

   function automatic logic [4:0] rand_code();
      int r = $urandom_range(0, 15);
      if (r < 10) return 5'(r);
      if (r < 13) return 5'h1F;
      return 5'($urandom_range(10, 30));
   endfunction

   task automatic model_reset();
      pos = 0;
      pd_full = 1'b0;
      for (int i = 0; i < N; i++) begin
         sh[i] = 5'h1F;
         pd[i] = 5'h1F;
      end
   endtask

   // Outputs after the coming edge, and the model state change at that edge.
   task automatic predict();
      int off;
      int slot;
      if (!rst_n) begin
         e_disp = 8'h00;
         e_sel  = '1;
         e_fs   = 1'b0;
         model_reset();
         return;
      end
      off  = pos % DIV;
      slot = (pos / DIV) % N;
      e_fs = (pos % FRAME == 0);
      if (off >= BLK && digit_en[slot]) begin
         e_disp = seg_of(sh[slot]);
         e_sel  = ~(N'(1) << slot);
      end else begin
         e_disp = 8'h00;
         e_sel  = '1;
      end
      if (pos % FRAME == FRAME - 1 && pd_full) begin
         for (int i = 0; i < N; i++) sh[i] = pd[i];
         pd_full = 1'b0;
      end else if (wr_valid && !pd_full) begin
         for (int i = 0; i < N; i++) pd[i] = wr_data[5*i +: 5];
         pd_full = 1'b1;
      end
      pos++;
   endtask

   // One clock: predict, let the edge pass, compare on the falling edge.
   task automatic tick();
      predict();
      @(posedge clk);
      @(negedge clk);
      chk("display", display, e_disp);
      chk("digit_sel", digit_sel, e_sel);
      chk("frame_start", frame_start, e_fs);
      chk("wr_ready", wr_ready, !pd_full);
   endtask

   task automatic wait_abs(input int n);
      int g = 0;
      while (pos < n && g < 1000) begin
         tick();
         g++;
      end
      if (pos < n) chk("wait_abs_timeout", 32'(pos), 32'(n));
   endtask

   task automatic write(input logic [5*N-1:0] d);
      wr_data  = d;
      wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      repeat (3) tick();
      chk("rst_sel", digit_sel, 4'hF);
      chk("rst_ready", wr_ready, 1);

      // Reset release and idle scan.
      rst_n = 1'b1;
      tick();
      chk("fs_first", frame_start, 1);
      chk("sel_first", digit_sel, 4'hF);
      tick();
      chk("fs_second", frame_start, 0);
      tick();
      chk("sel_d0", digit_sel, 4'b1110);
      chk("disp_idle", display, 8'h00);
      wait_abs(11);
      chk("sel_d1", digit_sel, 4'b1101);
      wait_abs(33);
      chk("fs_period", frame_start, 1);

      // Mid-frame write shown from the next frame.
      wait_abs(40);
      write({5'd3, 5'd2, 5'd1, 5'd0});
      chk("ready_low", wr_ready, 0);
      wait_abs(64);
      chk("ready_back", wr_ready, 1);
      wait_abs(67);
      chk("d0_code0", display, 8'b11101011);
      chk("d0_sel", digit_sel, 4'b1110);
      wait_abs(91);
      chk("d3_code3", display, 8'b10111010);
      chk("d3_sel", digit_sel, 4'b0111);

      // Second write held while pending is full.
      write({5'd8, 5'd8, 5'd8, 5'd8});
      wr_data  = {5'd1, 5'd1, 5'd1, 5'd1};
      wr_valid = 1'b1;
      tick();
      chk("held_ready", wr_ready, 0);
      wait_abs(97);
      wr_valid = 1'b0;
      chk("held_pending", wr_ready, 0);
      wait_abs(99);
      chk("first_frame8", display, 8'hFB);
      wait_abs(131);
      chk("second_frame1", display, 8'h28);

      // Disabled digit and lamp-test code.
      digit_en = 4'b1011;
      write({5'h0A, 5'd5, 5'd6, 5'd7});
      wait_abs(179);
      chk("dis_sel", digit_sel, 4'hF);
      chk("dis_disp", display, 8'h00);
      wait_abs(187);
      chk("lamp_disp", display, 8'hFF);
      chk("lamp_sel", digit_sel, 4'b0111);

      // Write landing in the wrap cycle waits a full frame.
      wait_abs(191);
      write({5'd9, 5'd9, 5'd9, 5'd9});
      chk("wrapwr_ready", wr_ready, 0);
      wait_abs(195);
      chk("wrapwr_old", display, 8'hA8);
      wait_abs(227);
      chk("wrapwr_new", display, 8'hFA);
      digit_en = '1;

      // Random traffic against the model.
      repeat (800) begin
         wr_valid = ($urandom_range(0, 2) == 0);
         for (int i = 0; i < N; i++) wr_data[5*i +: 5] = rand_code();
         if ($urandom_range(0, 15) == 0) digit_en = N'($urandom);
         tick();
      end
      wr_valid = 1'b0;
      digit_en = '1;

      // Reset during a SHOW cycle with a frame pending.
      begin
         int g = 0;
         while (pd_full && g < 100) begin
            tick();
            g++;
         end
      end
      write({5'd4, 5'd4, 5'd4, 5'd4});
      begin
         int g = 0;
         while (pos % DIV != 5 && g < 100) begin
            tick();
            g++;
         end
      end
      chk("pre_rst_pending", wr_ready, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_disp", display, 8'h00);
      chk("async_sel", digit_sel, 4'hF);
      chk("async_ready", wr_ready, 1);
      chk("async_fs", frame_start, 0);
      model_reset();
      @(negedge clk);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      chk("post_rst_sel", digit_sel, 4'b1110);
      chk("post_rst_blank", display, 8'h00);
      repeat (70) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
